// File: rtl/clint_pkg.sv
// Shared CLINT register map, reset constants and byte-merge helper.
package clint_pkg;

    localparam logic [15:0] MSIP_OFF        = 16'h0000;
    localparam logic [15:0] MTIMECMP_LO_OFF = 16'h4000;
    localparam logic [15:0] MTIMECMP_HI_OFF = 16'h4004;
    localparam logic [15:0] MTIME_LO_OFF    = 16'hBFF8;
    localparam logic [15:0] MTIME_HI_OFF    = 16'hBFFC;

    localparam logic [63:0] MTIMECMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF;

    // Replaces only the byte lanes selected by strb; other lanes keep old_val.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_prescaler.sv
// Divides clk into mtime ticks: one tick every PRESCALE cycles.
module clint_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/clint_timer.sv
// CLINT machine timer and software interrupt block with a simple bus port.
// Optional feature macro: CLINT_PRESCALE_EN (enables the PRESCALE divider).
module clint_timer
    import clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        timer_irq,
    output logic        software_irq,
    output logic [63:0] mtime
);

    logic        tick;
    logic        accept;
    logic        wr;
    logic        rd;
    logic [15:0] offset;
    logic [63:0] mtime_q;
    logic [63:0] mtime_next;
    logic [63:0] mtimecmp_q;
    logic [63:0] mtimecmp_next;
    logic        msip_q;
    logic [31:0] rdata_next;

`ifdef CLINT_PRESCALE_EN
    clint_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );
`else
    logic [31:0] unused_prescale;
    assign unused_prescale = 32'(PRESCALE);
    assign tick            = 1'b1;
`endif

    assign accept       = req_valid && (req_addr[31:16] == BASE_ADDR[31:16]);
    assign wr           = accept && req_we;
    assign rd           = accept && !req_we;
    assign offset       = req_addr[15:0];
    assign req_ready    = 1'b1;
    assign mtime        = mtime_q;
    assign software_irq = msip_q;

    // A software write to either mtime half replaces the tick for that cycle,
    // so the merge starts from the pre-tick value.
    always_comb begin
        mtime_next    = mtime_q + {63'b0, tick};
        mtimecmp_next = mtimecmp_q;
        if (wr) begin
            case (offset)
                MTIME_LO_OFF:
                    mtime_next = {mtime_q[63:32], merge_bytes(mtime_q[31:0], req_wdata, req_wstrb)};
                MTIME_HI_OFF:
                    mtime_next = {merge_bytes(mtime_q[63:32], req_wdata, req_wstrb), mtime_q[31:0]};
                MTIMECMP_LO_OFF:
                    mtimecmp_next = {mtimecmp_q[63:32], merge_bytes(mtimecmp_q[31:0], req_wdata, req_wstrb)};
                MTIMECMP_HI_OFF:
                    mtimecmp_next = {merge_bytes(mtimecmp_q[63:32], req_wdata, req_wstrb), mtimecmp_q[31:0]};
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata_next = '0;
        if (rd) begin
            case (offset)
                MSIP_OFF:        rdata_next = {31'b0, msip_q};
                MTIMECMP_LO_OFF: rdata_next = mtimecmp_q[31:0];
                MTIMECMP_HI_OFF: rdata_next = mtimecmp_q[63:32];
                MTIME_LO_OFF:    rdata_next = mtime_q[31:0];
                MTIME_HI_OFF:    rdata_next = mtime_q[63:32];
                default:         rdata_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mtime_q    <= '0;
            mtimecmp_q <= MTIMECMP_RESET;
            msip_q     <= 1'b0;
            timer_irq  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            mtime_q    <= mtime_next;
            mtimecmp_q <= mtimecmp_next;
            timer_irq  <= (mtime_next >= mtimecmp_next);
            if (wr && (offset == MSIP_OFF) && req_wstrb[0]) begin
                msip_q <= req_wdata[0];
            end
            rsp_valid  <= accept;
            rsp_rdata  <= rdata_next;
        end
    end

endmodule

// File: tb/tb_clint_timer.sv
// Directed self-checking bench for clint_timer; prescale test runs only with CLINT_PRESCALE_EN.
module tb_clint_timer;

`ifdef CLINT_PRESCALE_EN
    localparam int unsigned TB_PRESCALE = 4;
`else
    localparam int unsigned TB_PRESCALE = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        timer_irq;
    logic        software_irq;
    logic [63:0] mtime;

    int n_checks = 0;
    int n_fail   = 0;

    clint_timer #(
        .BASE_ADDR (32'h0200_0000),
        .PRESCALE  (TB_PRESCALE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_we       (req_we),
        .req_wdata    (req_wdata),
        .req_wstrb    (req_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .timer_irq    (timer_irq),
        .software_irq (software_irq),
        .mtime        (mtime)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // One bus transfer; returns on the negedge where its response is visible.
    task automatic applyStimulus(input logic [31:0] addr, input logic we,
                                 input logic [31:0] wdata, input logic [3:0] wstrb);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = addr;
        req_we    = we;
        req_wdata = wdata;
        req_wstrb = wstrb;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_wdata = '0;
        req_wstrb = '0;
    endtask

    task automatic waitMtime(input logic [63:0] target, input string tag);
        bit found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (mtime == target) found = 1;
            else @(negedge clk);
        end
        if (!found) checkOutput(tag, 64'd0, 64'd1);
    endtask

    initial begin
        rst_n     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_we    = 1'b0;
        req_wdata = '0;
        req_wstrb = '0;

        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_mtime", mtime, 64'd0);
        checkOutput("rst_tirq", timer_irq, 1'b0);
        checkOutput("rst_sirq", software_irq, 1'b0);
        checkOutput("rst_rspv", rsp_valid, 1'b0);
        checkOutput("req_ready", req_ready, 1'b1);
        rst_n = 1'b1;

`ifdef CLINT_PRESCALE_EN
        repeat (39) @(negedge clk);
        checkOutput("psc_mtime39", mtime, 64'd9);
        @(negedge clk);
        checkOutput("psc_mtime40", mtime, 64'd10);
        applyStimulus(32'h0200_BFF8, 1'b0, 32'd0, 4'h0);
        checkOutput("psc_rd_lo", rsp_rdata, 32'd10);
        applyStimulus(32'h0200_4004, 1'b0, 32'd0, 4'h0);
        checkOutput("rst_cmp_hi", rsp_rdata, 32'hFFFF_FFFF);
`else
        applyStimulus(32'h0200_4004, 1'b0, 32'd0, 4'h0);
        checkOutput("rst_cmp_hi_v", rsp_valid, 1'b1);
        checkOutput("rst_cmp_hi", rsp_rdata, 32'hFFFF_FFFF);

        // Read returns mtime from before the accepting edge.
        applyStimulus(32'h0200_BFFC, 1'b1, 32'd0, 4'hF);
        applyStimulus(32'h0200_BFF8, 1'b1, 32'd100, 4'hF);
        checkOutput("wr_mtime", mtime, 64'd100);
        checkOutput("wr_rdata0", rsp_rdata, 32'd0);
        applyStimulus(32'h0200_BFF8, 1'b0, 32'd0, 4'h0);
        checkOutput("rd_mtime_pre", rsp_rdata, 32'd101);
        checkOutput("rd_mtime_now", mtime, 64'd102);

        // Compare threshold at 20.
        applyStimulus(32'h0200_BFF8, 1'b1, 32'd0, 4'hF);
        applyStimulus(32'h0200_4000, 1'b1, 32'd20, 4'hF);
        applyStimulus(32'h0200_4004, 1'b1, 32'd0, 4'hF);
        checkOutput("cmp_mtime4", mtime, 64'd4);
        checkOutput("cmp_irq_lo", timer_irq, 1'b0);
        waitMtime(64'd19, "cmp_timeout");
        checkOutput("cmp_irq19", timer_irq, 1'b0);
        @(negedge clk);
        checkOutput("cmp_mtime20", mtime, 64'd20);
        checkOutput("cmp_irq20", timer_irq, 1'b1);
        applyStimulus(32'h0200_4004, 1'b1, 32'd1, 4'hF);
        checkOutput("cmp_irq_clr", timer_irq, 1'b0);

        // Lo-to-hi carry, then compare across the halves.
        applyStimulus(32'h0200_BFFC, 1'b1, 32'd0, 4'hF);
        applyStimulus(32'h0200_BFF8, 1'b1, 32'hFFFF_FFFE, 4'hF);
        checkOutput("carry_0", mtime, 64'h0_FFFF_FFFE);
        @(negedge clk);
        checkOutput("carry_1", mtime, 64'h0_FFFF_FFFF);
        @(negedge clk);
        checkOutput("carry_2", mtime, 64'h1_0000_0000);
        checkOutput("carry_irq", timer_irq, 1'b0);
        waitMtime(64'h1_0000_0013, "carry_timeout");
        checkOutput("hi_irq19", timer_irq, 1'b0);
        @(negedge clk);
        checkOutput("hi_irq20", timer_irq, 1'b1);

        // Byte-masked writes on tick cycles.
        applyStimulus(32'h0200_BFFC, 1'b1, 32'd0, 4'hF);
        checkOutput("mtime_wr_clr", timer_irq, 1'b0);
        applyStimulus(32'h0200_BFF8, 1'b1, 32'h1234_5678, 4'hF);
        applyStimulus(32'h0200_BFF8, 1'b1, 32'h0000_0005, 4'b0001);
        checkOutput("coll_lo", mtime, 64'h0000_0000_1234_5605);
        @(negedge clk);
        checkOutput("coll_resume", mtime, 64'h0000_0000_1234_5606);
        applyStimulus(32'h0200_BFFC, 1'b1, 32'hAB00_0000, 4'b1000);
        checkOutput("coll_hi", mtime, 64'hAB00_0000_1234_5607);

        // Software interrupt.
        applyStimulus(32'h0200_0000, 1'b1, 32'd1, 4'b0001);
        checkOutput("msip_set", software_irq, 1'b1);
        checkOutput("msip_wr_rd0", rsp_rdata, 32'd0);
        applyStimulus(32'h0200_0000, 1'b0, 32'd0, 4'h0);
        checkOutput("msip_rd", rsp_rdata, 32'd1);
        applyStimulus(32'h0200_0000, 1'b1, 32'd0, 4'b0010);
        checkOutput("msip_nostrb", software_irq, 1'b1);
        applyStimulus(32'h0200_0000, 1'b1, 32'd0, 4'b0001);
        checkOutput("msip_clr", software_irq, 1'b0);

        // Unmapped offsets and foreign regions.
        applyStimulus(32'h0200_0008, 1'b0, 32'd0, 4'h0);
        checkOutput("unmap_rd_v", rsp_valid, 1'b1);
        checkOutput("unmap_rd", rsp_rdata, 32'd0);
        applyStimulus(32'h0200_0010, 1'b1, 32'hDEAD_BEEF, 4'hF);
        checkOutput("unmap_wr_v", rsp_valid, 1'b1);
        applyStimulus(32'h0300_BFF8, 1'b0, 32'd0, 4'h0);
        checkOutput("foreign_v", rsp_valid, 1'b0);

        // Back-to-back reads.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0200_4000;
        @(negedge clk);
        checkOutput("b2b_v0", rsp_valid, 1'b1);
        checkOutput("b2b_d0", rsp_rdata, 32'd20);
        req_addr = 32'h0200_4004;
        @(negedge clk);
        checkOutput("b2b_v1", rsp_valid, 1'b1);
        checkOutput("b2b_d1", rsp_rdata, 32'd1);
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("b2b_idle", rsp_valid, 1'b0);

        // Reset with a request in flight drops its response.
        applyStimulus(32'h0200_0000, 1'b1, 32'd1, 4'b0001);
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0200_BFF8;
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 1'b0;
        checkOutput("rstreq_v0", rsp_valid, 1'b0);
        checkOutput("rstreq_sirq", software_irq, 1'b0);
        checkOutput("rstreq_mtime", mtime, 64'd0);
        @(negedge clk);
        checkOutput("rstreq_v1", rsp_valid, 1'b0);
        checkOutput("rstreq_tick", mtime, 64'd1);
        applyStimulus(32'h0200_4004, 1'b0, 32'd0, 4'h0);
        checkOutput("rstreq_cmp", rsp_rdata, 32'hFFFF_FFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
